square_anim_ctrl: RTL and testbench
===================================

// Module: square_anim_ctrl
// PURPOSE
//  Animation controller for the VGA square demo. It owns the position and direction of
//  N_SQ squares and advances them once per frame while the screen is blanked, bouncing
//  each square off the screen edges. For the current pixel (i_x, i_y) it returns a
//  per-square hit vector that the top level maps onto VGA colour bits.
//  Sits between the vga640x480 timing generator and the colour outputs.
// PARAMETERS
//  N_SQ   4    number of squares (1..8)
//  SIZE   160  square edge in pixels; active interior is exclusive: x>L & x<L+SIZE
//  SPEED  1    pixels moved per axis per frame (1..15)
//  H_RES  640  horizontal active pixels
//  V_RES  480  vertical active lines
// PORTS
//  i_clk      in   1      system clock (100 MHz)
//  i_rst_n    in   1      reset, asynchronous, active-low
//  i_pix_stb  in   1      pixel strobe, 1 cycle in 4
//  i_animate  in   1      1-cycle pulse at start of vertical blank (from timing gen)
//  i_pause    in   1      level; 1 = freeze positions
//  i_x        in   10     current pixel x
//  i_y        in   9      current pixel y
//  o_sq       out  N_SQ   per-square hit, bit k = pixel inside square k
//  o_busy     out  1      update sequence in progress
//  o_done     out  1      1-cycle pulse when the update sequence completes
//  o_overrun  out  1      sticky: i_animate arrived while busy
// BEHAVIOUR
//  Reset (asynchronous, i_rst_n=0): square k gets L=120+80k, T=40+80k, dx=+, dy=+.
//   o_sq=0, o_busy=0, o_done=0, o_overrun=0, FSM=IDLE, idx=0.
//  FSM: IDLE -> UPD (one square per clock, idx 0..N_SQ-1) -> FIN -> IDLE.
//   IDLE: i_animate=1 -> UPD, idx=0, o_busy=1 on the next cycle.
//   UPD: update square idx. If idx==N_SQ-1 go to FIN, otherwise idx+1.
//   FIN: o_done=1 for this cycle, o_busy=0 from the next cycle, return to IDLE.
//   Latency: i_animate at cycle t gives o_done at t+N_SQ+1. o_busy is high for N_SQ+1 cycles.
//  Per-square update (X axis; the Y axis is identical using T, dy, V_RES):
//   Arithmetic is 11-bit unsigned, so no wrap is possible.
//   dx=+ and L+SIZE+SPEED > H_RES-1: L = H_RES-1-SIZE, dx flips to -.
//   dx=- and L < SPEED: L = 0, dx flips to +.
//   Otherwise: L = L +/- SPEED.
//   i_pause=1 at the UPD cycle: L, T, dx and dy are held. o_done still pulses.
//  Simultaneous and boundary events:
//   i_animate while o_busy=1: the pulse is dropped and o_overrun is set. o_overrun is
//    cleared only by reset.
//   i_animate in the FIN cycle: counts as busy, so it is dropped and o_overrun is set.
//   Reset mid-sequence: immediate return to reset state. Partially updated squares revert.
//  Hit test: on cycles with i_pix_stb=1, o_sq[k] <= (i_x>L_k)&(i_x<L_k+SIZE)&
//   (i_y>T_k)&(i_y<T_k+SIZE). Otherwise o_sq holds its value.
//   Latency is one pixel strobe. Comparisons use 11-bit values.
//   The hit test reads the current registers even while busy. The update runs in blanking.
// TESTING
//  T1 reset: release i_rst_n -> o_sq=0, busy=0, done=0, overrun=0.
//     Pixel (121,41) with a strobe -> o_sq=4'b0001.
//     Pixel (120,41) -> o_sq=0 (boundary is exclusive).
//  T2 single frame: pulse i_animate at cycle t -> busy for t+1..t+5, done at t+5.
//     Square0 is then at L=121, T=41, so pixel (121,41) -> o_sq[0]=0.
//  T3 bounce: 39 frames -> square3 T=319. Frame 40 -> T=319 and dy=-. Frame 41 -> T=318.
//     Same frames on X: square3 L=399, 400, ...
//  T4 pause: i_pause=1 for 3 frames -> all L and T unchanged, 3 done pulses, no overrun.
//  T5 overrun: second i_animate 2 cycles after the first -> overrun=1, only one update applied.
//     overrun stays 1 after further frames.
//  T6 reset mid-sequence: assert i_rst_n=0 in UPD with idx=2 -> outputs clear
//     asynchronously and all squares return to their reset positions.

Source files
------------

// File: rtl/square_anim_ctrl.sv
// Animation controller for the VGA square demo.
// Keeps position and direction for N_SQ squares, advances them one square per
// clock during vertical blank, bounces them off the screen edges, and returns a
// registered per-square hit vector for the current pixel.
module square_anim_ctrl #(
    parameter int N_SQ  = 4,
    parameter int SIZE  = 160,
    parameter int SPEED = 1,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_pix_stb,
    input  logic            i_animate,
    input  logic            i_pause,
    input  logic [9:0]      i_x,
    input  logic [8:0]      i_y,
    output logic [N_SQ-1:0] o_sq,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_overrun
);

    localparam int IDX_W = (N_SQ > 1) ? $clog2(N_SQ) : 1;

    // All position arithmetic is 11-bit unsigned; the largest intermediate
    // (L + SIZE + SPEED) stays far below 2048, so nothing wraps.
    localparam logic [10:0] SZ    = 11'(SIZE);
    localparam logic [10:0] SP    = 11'(SPEED);
    localparam logic [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic [10:0] Y_MAX = 11'(V_RES - 1);
    localparam logic [10:0] X_LIM = 11'(H_RES - 1 - SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_RES - 1 - SIZE);

    typedef enum logic [1:0] {ST_IDLE, ST_UPD, ST_FIN} state_t;

    typedef struct packed {
        logic [10:0] pos;
        logic        dir_pos;   // 1 = moving towards larger coordinates
    } axis_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [10:0]       l_q [N_SQ];
    logic [10:0]       t_q [N_SQ];
    logic [N_SQ-1:0]   dx_q;
    logic [N_SQ-1:0]   dy_q;
    logic [N_SQ-1:0]   sq_q;

    axis_t             x_d;
    axis_t             y_d;
    logic [N_SQ-1:0]   sq_d;

    // One axis step with edge bounce: the far edge clamps so the square's
    // right/bottom side lands on the last visible pixel, the near edge clamps to 0.
    function automatic axis_t axis_step(input logic [10:0] pos,
                                        input logic        dir_pos,
                                        input logic [10:0] res_max,
                                        input logic [10:0] lim);
        axis_t r;
        r.pos     = pos;
        r.dir_pos = dir_pos;
        if (dir_pos) begin
            if (pos + SZ + SP > res_max) begin
                r.pos     = lim;
                r.dir_pos = 1'b0;
            end else begin
                r.pos = pos + SP;
            end
        end else begin
            if (pos < SP) begin
                r.pos     = '0;
                r.dir_pos = 1'b1;
            end else begin
                r.pos = pos - SP;
            end
        end
        return r;
    endfunction

    // Next position/direction of the square currently addressed by idx
    always_comb begin
        x_d = axis_step(l_q[idx_q], dx_q[idx_q], X_MAX, X_LIM);
        y_d = axis_step(t_q[idx_q], dy_q[idx_q], Y_MAX, Y_LIM);
    end

    // Exclusive-interior hit test of the current pixel against every square
    always_comb begin
        sq_d = '0;
        for (int k = 0; k < N_SQ; k++) begin
            sq_d[k] = ({1'b0, i_x} > l_q[k]) && ({1'b0, i_x} < l_q[k] + SZ) &&
                      ({2'b0, i_y} > t_q[k]) && ({2'b0, i_y} < t_q[k] + SZ);
        end
    end

    // Sequencer: IDLE -> UPD (one square per clock) -> FIN -> IDLE, registered flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_animate) begin
                        state_q <= ST_UPD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_UPD: begin
                    if (i_animate) overrun_q <= 1'b1;
                    if (idx_q == IDX_W'(N_SQ - 1)) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_FIN: begin
                    // A pulse landing here is still inside the sequence: drop it.
                    if (i_animate) overrun_q <= 1'b1;
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Square state: reset to the staggered start layout, update one square per UPD cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_SQ; k++) begin
                l_q[k] <= 11'(120 + 80 * k);
                t_q[k] <= 11'(40 + 80 * k);
            end
            dx_q <= '1;
            dy_q <= '1;
        end else if (state_q == ST_UPD && !i_pause) begin
            l_q[idx_q]  <= x_d.pos;
            dx_q[idx_q] <= x_d.dir_pos;
            t_q[idx_q]  <= y_d.pos;
            dy_q[idx_q] <= y_d.dir_pos;
        end
    end

    // Hit vector is captured on pixel strobes only and held in between
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sq_q <= '0;
        end else if (i_pix_stb) begin
            sq_q <= sq_d;
        end
    end

    assign o_sq      = sq_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_square_anim_ctrl.sv
// Self-checking bench for square_anim_ctrl: directed scenarios plus randomized
// frames and pixel probes, checked against a plain arithmetic model of the squares.
module tb_square_anim_ctrl;

    localparam int N_SQ  = 4;
    localparam int SIZE  = 160;
    localparam int SPEED = 1;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pix_stb = 1'b0;
    logic            animate = 1'b0;
    logic            pause = 1'b0;
    logic [9:0]      x = '0;
    logic [8:0]      y = '0;
    logic [N_SQ-1:0] sq;
    logic            busy;
    logic            done;
    logic            overrun;

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the squares: position and direction (+1 / -1) per axis
    int mL [N_SQ];
    int mT [N_SQ];
    int mdx[N_SQ];
    int mdy[N_SQ];
    logic exp_ovr;
    logic [N_SQ-1:0] last_hit;

    square_anim_ctrl #(
        .N_SQ(N_SQ), .SIZE(SIZE), .SPEED(SPEED), .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_pix_stb(pix_stb),
        .i_animate(animate),
        .i_pause  (pause),
        .i_x      (x),
        .i_y      (y),
        .o_sq     (sq),
        .o_busy   (busy),
        .o_done   (done),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N_SQ; k++) begin
            mL[k] = 120 + 80 * k;
            mT[k] = 40 + 80 * k;
            mdx[k] = 1;
            mdy[k] = 1;
        end
    endfunction

    // Move along one axis; the square's far side may reach res-1 at most.
    function automatic void move(inout int p, inout int d, input int res);
        int np;
        np = p + d * SPEED;
        if (np + SIZE > res - 1) begin
            p = res - 1 - SIZE;
            d = -1;
        end else if (np < 0) begin
            p = 0;
            d = 1;
        end else begin
            p = np;
        end
    endfunction

    function automatic void model_frame(input bit pz);
        if (!pz) begin
            for (int k = 0; k < N_SQ; k++) begin
                move(mL[k], mdx[k], H_RES);
                move(mT[k], mdy[k], V_RES);
            end
        end
    endfunction

    function automatic logic [N_SQ-1:0] model_hit(input int px, input int py);
        logic [N_SQ-1:0] h;
        h = '0;
        for (int k = 0; k < N_SQ; k++)
            h[k] = (px > mL[k]) && (px < mL[k] + SIZE) && (py > mT[k]) && (py < mT[k] + SIZE);
        return h;
    endfunction

    task automatic probe(input string tag, input int px, input int py);
        @(negedge clk);
        x = px[9:0];
        y = py[8:0];
        pix_stb = 1'b1;
        @(negedge clk);
        pix_stb = 1'b0;
        last_hit = model_hit(int'(x), int'(y));
        chk(tag, 32'(sq), 32'(last_hit));
    endtask

    task automatic probe_square(input string tag, input int k);
        probe(tag, mL[k] + 1, mT[k] + 1);
        probe(tag, mL[k], mT[k] + 1);
        probe(tag, mL[k] + 1, mT[k]);
        probe(tag, mL[k] + SIZE - 1, mT[k] + SIZE - 1);
        probe(tag, mL[k] + SIZE, mT[k] + SIZE - 1);
        probe(tag, mL[k] + SIZE - 1, mT[k] + SIZE);
    endtask

    task automatic probe_all(input string tag);
        for (int k = 0; k < N_SQ; k++) probe_square(tag, k);
    endtask

    // One animate pulse and a cycle-by-cycle check of busy/done
    task automatic frame(input bit pz, input string tag);
        @(negedge clk);
        animate = 1'b1;
        pause = pz;
        for (int n = 1; n <= N_SQ + 2; n++) begin
            @(negedge clk);
            animate = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'(n <= N_SQ + 1));
            chk({tag, "_done"}, 32'(done), 32'(n == N_SQ + 1));
        end
        pause = 1'b0;
        model_frame(pz);
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        model_reset();
        exp_ovr = 1'b0;

        // T1: reset state and exclusive boundary
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        probe("t1_in", 121, 41);
        chk("t1_in_const", 32'(sq), 32'h1);
        probe("t1_edge", 120, 41);
        chk("t1_edge_const", 32'(sq), 32'h0);
        probe_all("t1_corner");

        // T2: single frame moves square 0 off pixel (121,41)
        frame(1'b0, "t2");
        probe("t2_px", 121, 41);
        chk("t2_px_const", 32'(sq[0]), 32'h0);
        probe_all("t2_corner");

        // T3: bounce of square 3 at the bottom edge (frames 39, 40, 41)
        for (int f = 2; f <= 41; f++) begin
            frame(1'b0, "t3");
            if (f >= 39) probe_square("t3_sq3", 3);
        end
        probe("t3_pos41", 400 + 2, 318 + 1);
        chk("t3_pos41_bit", 32'(sq[3]), 32'h1);
        probe("t3_top41", 402, 318);
        chk("t3_top41_bit", 32'(sq[3]), 32'h0);

        // T4: paused frames keep positions but still pulse done
        for (int f = 0; f < 3; f++) frame(1'b1, "t4");
        probe_all("t4_corner");

        // T5: second pulse mid-sequence is dropped and flags overrun
        @(negedge clk);
        animate = 1'b1;
        @(negedge clk);
        animate = 1'b0;
        @(negedge clk);
        animate = 1'b1;
        @(negedge clk);
        animate = 1'b0;
        chk("t5_ovr", 32'(overrun), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_done", 32'(done), 32'h1);
        @(negedge clk);
        chk("t5_idle", 32'(busy), 32'h0);
        model_frame(1'b0);
        exp_ovr = 1'b1;
        probe_all("t5_corner");
        frame(1'b0, "t5_more");
        frame(1'b0, "t5_more");

        // Randomized frames and probes, hold behaviour between strobes
        for (int f = 0; f < 20; f++) begin
            frame($urandom_range(0, 3) == 0, "rnd");
            probe_square("rnd_sq", $urandom_range(0, N_SQ - 1));
            for (int p = 0; p < 3; p++)
                probe("rnd_px", $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1));
            @(negedge clk);
            x = 10'($urandom_range(0, H_RES - 1));
            y = 9'($urandom_range(0, V_RES - 1));
            @(negedge clk);
            chk("rnd_hold", 32'(sq), 32'(last_hit));
        end

        // T6: asynchronous reset in the middle of the update (idx 2)
        @(negedge clk);
        animate = 1'b1;
        @(negedge clk);
        animate = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_ovr", 32'(overrun), 32'h0);
        chk("t6_sq", 32'(sq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exp_ovr = 1'b0;
        probe_all("t6_corner");

        // Pulse landing in the FIN cycle is dropped too
        @(negedge clk);
        animate = 1'b1;
        @(negedge clk);
        animate = 1'b0;
        repeat (N_SQ) @(negedge clk);
        chk("fin_done", 32'(done), 32'h1);
        animate = 1'b1;
        @(negedge clk);
        animate = 1'b0;
        chk("fin_ovr", 32'(overrun), 32'h1);
        chk("fin_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("fin_busy2", 32'(busy), 32'h0);
        model_frame(1'b0);
        exp_ovr = 1'b1;
        probe_all("fin_corner");
        frame(1'b0, "fin_next");
        probe_all("fin_next_corner");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
